uart_rx_sampler: RTL
====================

// Module: uart_rx_sampler
// PURPOSE
//  Oversampling UART receiver that sits upstream of the 32x4 capture RAM.
//  It synchronises the GPIO serial line and validates start and stop bits.
//  It emits each received byte with a one-cycle write strobe and a
//  self-incrementing 5-bit write address, ready to drive the RAM write port.
// PARAMETERS
//  CLK_HZ      50_000_000  system clock frequency
//  BAUD        9600        line rate; override to a high value in simulation
//  OVERSAMPLE  16          sample ticks per bit; must be even and >= 8
//  DATA_BITS   8           payload bits per frame, sent LSB first
//  ADDR_W      5           write-address width (RAM depth = 2**ADDR_W)
// PORTS
//  CLOCK_50   in   1          system clock; all logic on the rising edge
//  Reset_n    in   1          asynchronous reset, active-low
//  rx_in      in   1          raw serial line (idles high), asynchronous to CLOCK_50
//  addr_clr   in   1          synchronous clear of wr_addr
//  rx_data    out  DATA_BITS  last good byte; held until the next good byte
//  rx_valid   out  1          one-cycle pulse when rx_data updates
//  wr_en      out  1          one-cycle RAM write strobe, same cycle as rx_valid
//  wr_addr    out  ADDR_W     RAM write address for the current wr_en
//  frame_err  out  1          one-cycle pulse on a bad stop bit (or bad parity)
//  busy       out  1          high in every state except IDLE
// BEHAVIOUR
//  Reset values: rx_data=0, rx_valid=0, wr_en=0, wr_addr=0, frame_err=0, busy=0.
//   Synchroniser flops reset to 1. FSM resets to IDLE.
//  rx_in passes through a 2-FF synchroniser; the FSM sees only rx_s.
//  Tick: divider DIV = CLK_HZ/(BAUD*OVERSAMPLE), truncated (325 at defaults).
//   Divider free-runs and is restarted on entry to START.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  IDLE:  a 1->0 transition on rx_s -> START; the tick counter is cleared.
//  START: after OVERSAMPLE/2 ticks, sample rx_s.
//   If rx_s=1, it is a false start -> IDLE, with no outputs.
//   If rx_s=0 -> DATA; the bit counter is cleared.
//  DATA: every OVERSAMPLE ticks (bit centre), shift rx_s in, LSB first.
//   After DATA_BITS samples -> PARITY if enabled, else STOP.
//  STOP: after OVERSAMPLE ticks, sample rx_s.
//   If rx_s=1 and no parity error: rx_data<=shift reg; rx_valid and wr_en
//    pulse next cycle; wr_addr increments the cycle after wr_en.
//   Otherwise: frame_err pulses, with no rx_valid or wr_en, and wr_addr is
//    unchanged.
//   Either case -> IDLE.
//  A break (line held low) never retriggers, because IDLE needs a falling edge.
//  Latency: rx_valid occurs about 1 tick + 3 clocks after the stop-bit centre.
//  wr_addr wraps from 2**ADDR_W-1 to 0; it is never saturated.
//  addr_clr: wr_addr<=0 next cycle.
//   If it coincides with wr_en, the write uses the pre-clear address and the
//   address ends at 0; clear wins over increment.
//   addr_clr never affects the FSM.
//  Reset asserted mid-frame: all state returns to reset values immediately.
//   A partial frame is discarded.
//   After release, reception waits for a fresh falling edge.
// CONFIGURATION
//  `UART_RX_PARITY_EN defined: a PARITY state after DATA samples one extra bit
//   at bit centre and requires even parity over data+parity.
//   A mismatch is flagged as frame_err at STOP, with no write.
//  Not defined: no PARITY state; frames are 8N1 and stop-bit error is the only
//   frame_err source.
// STRUCTURE
//  Package uart_rx_pkg: state enum (IDLE, START, DATA, PARITY, STOP) and a
//   localparam function computing DIV from CLK_HZ/BAUD/OVERSAMPLE.
//  Sub-module uart_baud_tick: divider with a sync restart input and a
//   one-cycle tick output.
//   Synchroniser, FSM, shift register and address counter live in the top.
// TESTING
//  Reset then idle line -> all outputs 0, busy=0, for 100 bit-times.
//  Send 8N1 0x35 -> one rx_valid and wr_en, rx_data=8'h35, wr_addr=0 during
//   wr_en, then 1.
//  Low glitch of 3 ticks on rx_in -> false start: no rx_valid, busy back to 0.
//  0xA5 with stop bit 0 -> frame_err pulse, no wr_en, wr_addr unchanged;
//   a following 0x11 is received correctly.
//  Send 33 bytes -> byte 32 written at wr_addr=31, byte 33 at wr_addr=0;
//   addr_clr together with wr_en -> write at old address, then wr_addr=0.
//  Reset_n low during DATA bit 4 -> outputs 0 at once; the next frame 0x7E
//   is received intact.
//   With `UART_RX_PARITY_EN, wrong parity gives frame_err and no write.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the oversampling UART receiver.
//   state_e  : receiver FSM states
//   calc_div : clock cycles per oversample tick, CLK_HZ/(BAUD*OVERSAMPLE) truncated
package uart_rx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        int unsigned div;
        div = clk_hz / (baud * oversample);
        // A zero divider would never tick; clamp to one tick per clock.
        return (div == 0) ? 1 : div;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator.
//   clk_i     : system clock
//   rst_ni    : asynchronous active-low reset
//   restart_i : synchronous restart; counter returns to 0, no tick this cycle
//   tick_o    : one-cycle pulse every DIV clocks
module uart_baud_tick #(
    parameter int unsigned DIV = 325
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic restart_i,
    output logic tick_o
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] Last = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (restart_i || (cnt_q == Last)) begin
            cnt_d = '0;
        end
    end

    assign tick_o = (cnt_q == Last) && !restart_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_sampler.sv
// Oversampling UART receiver feeding a capture RAM write port.
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit after the data bits.
//   CLOCK_50  : system clock
//   Reset_n   : asynchronous active-low reset
//   rx_in     : raw serial line, idles high, asynchronous
//   addr_clr  : synchronous clear of wr_addr (wins over increment)
//   rx_data   : last good byte, held until the next good byte
//   rx_valid  : one-cycle pulse when rx_data updates
//   wr_en     : one-cycle RAM write strobe, coincident with rx_valid
//   wr_addr   : RAM write address for the current wr_en, wraps
//   frame_err : one-cycle pulse on bad stop bit (or bad parity)
//   busy      : high whenever the FSM is not idle
module uart_rx_sampler #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned ADDR_W     = 5
) (
    input  logic                 CLOCK_50,
    input  logic                 Reset_n,
    input  logic                 rx_in,
    input  logic                 addr_clr,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic                 frame_err,
    output logic                 busy
);

    import uart_rx_pkg::*;

    localparam int unsigned Div   = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int unsigned TickW = $clog2(OVERSAMPLE);
    localparam int unsigned BitW  = $clog2(DATA_BITS + 1);
    localparam logic [TickW-1:0] HalfLast = TickW'(OVERSAMPLE / 2 - 1);
    localparam logic [TickW-1:0] FullLast = TickW'(OVERSAMPLE - 1);
    localparam logic [BitW-1:0]  LastBit  = BitW'(DATA_BITS - 1);

    // Synchroniser and edge detector; all reset high to match an idle line.
    logic rx_meta_q, rx_s_q, rx_prev_q;
    logic fall;

    state_e state_q, state_d;

    logic [TickW-1:0]     tick_cnt_q, tick_cnt_d;
    logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 wr_en_q, wr_en_d;
    logic                 frame_err_q, frame_err_d;
    logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;

    logic restart, tick, bit_done, parity_bad;

`ifdef UART_RX_PARITY_EN
    logic parity_err_q, parity_err_d;
    assign parity_bad = parity_err_q;
`else
    assign parity_bad = 1'b0;
`endif

    uart_baud_tick #(
        .DIV (Div)
    ) u_baud_tick (
        .clk_i     (CLOCK_50),
        .rst_ni    (Reset_n),
        .restart_i (restart),
        .tick_o    (tick)
    );

    assign fall     = rx_prev_q && !rx_s_q;
    assign bit_done = tick && (tick_cnt_q == FullLast);

    always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
        if (!Reset_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_in;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    // State register
    always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                // Needs an edge, so a held-low break cannot retrigger.
                if (fall) state_d = StStart;
            end
            StStart: begin
                if (tick && (tick_cnt_q == HalfLast)) begin
                    state_d = rx_s_q ? StIdle : StData;
                end
            end
            StData: begin
                if (bit_done && (bit_cnt_q == LastBit)) begin
`ifdef UART_RX_PARITY_EN
                    state_d = StParity;
`else
                    state_d = StStop;
`endif
                end
            end
            StParity: begin
                if (bit_done) state_d = StStop;
            end
            StStop: begin
                if (bit_done) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output and datapath logic
    always_comb begin
        restart     = 1'b0;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        wr_en_d     = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err_d = parity_err_q;
`endif

        // The address advances the cycle after the write it served.
        wr_addr_d = wr_addr_q;
        if (addr_clr) begin
            wr_addr_d = '0;
        end else if (wr_en_q) begin
            wr_addr_d = wr_addr_q + ADDR_W'(1);
        end

        if (tick) tick_cnt_d = tick_cnt_q + TickW'(1);

        unique case (state_q)
            StIdle: begin
                if (fall) begin
                    restart    = 1'b1;
                    tick_cnt_d = '0;
                end
            end
            StStart: begin
                if (tick && (tick_cnt_q == HalfLast)) begin
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
`ifdef UART_RX_PARITY_EN
                    parity_err_d = 1'b0;
`endif
                end
            end
            StData: begin
                if (bit_done) begin
                    tick_cnt_d = '0;
                    shift_d    = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d  = bit_cnt_q + BitW'(1);
                end
            end
            StParity: begin
`ifdef UART_RX_PARITY_EN
                if (bit_done) begin
                    tick_cnt_d   = '0;
                    parity_err_d = ^{shift_q, rx_s_q};
                end
`endif
            end
            StStop: begin
                if (bit_done) begin
                    if (rx_s_q && !parity_bad) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                        wr_en_d    = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
        if (!Reset_n) begin
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            frame_err_q <= 1'b0;
            wr_addr_q   <= '0;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            wr_en_q     <= wr_en_d;
            frame_err_q <= frame_err_d;
            wr_addr_q   <= wr_addr_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
        if (!Reset_n) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end
`endif

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != StIdle);

endmodule
